// File: rtl/tlb_maint_ctrl.sv
// Maintenance controller for a fully-associative TLB tag array: sequences
// sfence.vma flush scans and picks refill victims with a tree pseudo-LRU.
//
// state | meaning
// IDLE  | waiting; refills may be granted, flush requests accepted
// SCAN  | walking the tag array, invalidating matching entries
// DONE  | flush complete, ack pulsed for one cycle
module tlb_maint_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int ASID_WIDTH  = 16,
    localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_req_i,
    input  logic                  flush_all_asid_i,
    input  logic                  flush_all_addr_i,
    input  logic [ASID_WIDTH-1:0] flush_asid_i,
    input  logic [26:0]           flush_vpn_i,
    output logic                  flush_ack_o,
    output logic                  busy_o,
    output logic [IDX_W-1:0]      tag_idx_o,
    input  logic                  tag_valid_i,
    input  logic                  tag_is_2M_i,
    input  logic                  tag_is_1G_i,
    input  logic [ASID_WIDTH-1:0] tag_asid_i,
    input  logic [26:0]           tag_vpn_i,
    input  logic [TLB_ENTRIES-1:0] valid_vec_i,
    output logic                  inv_valid_o,
    output logic [IDX_W-1:0]      inv_idx_o,
    output logic                  inv_all_o,
    input  logic                  refill_req_i,
    output logic                  refill_gnt_o,
    output logic [IDX_W-1:0]      refill_idx_o,
    input  logic                  hit_valid_i,
    input  logic [IDX_W-1:0]      hit_idx_i
);

    localparam int NODES = TLB_ENTRIES - 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state;
    logic [IDX_W-1:0]      cnt;
    logic [ASID_WIDTH-1:0] f_asid;
    logic [26:0]           f_vpn;
    logic                  f_all_asid;
    logic                  f_all_addr;
    logic [NODES-1:0]      plru_q;
    logic [NODES-1:0]      plru_hit;
    logic [NODES-1:0]      plru_next;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic                  vpn_eq;
    logic                  match;

    // Heap-ordered tree: the node at level l on the path of idx is
    // (2^l - 1) + (top l bits of idx).
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                     input logic [IDX_W-1:0] idx);
        logic [NODES-1:0] t;
        logic [IDX_W-1:0] node;
        t = tree;
        for (int l = 0; l < IDX_W; l++) begin
            node    = IDX_W'((1 << l) - 1) + (idx >> (IDX_W - l));
            t[node] = ~idx[IDX_W-1-l];
        end
        return t;
    endfunction

    function automatic logic [IDX_W-1:0] plru_victim(input logic [NODES-1:0] tree);
        logic [IDX_W-1:0] v;
        logic [IDX_W-1:0] node;
        v = '0;
        for (int l = 0; l < IDX_W; l++) begin
            node          = IDX_W'((1 << l) - 1) + (v >> (IDX_W - l));
            v[IDX_W-1-l]  = tree[node];
        end
        return v;
    endfunction

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec_i[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign refill_idx_o = free_found ? free_idx : plru_victim(plru_q);
    assign refill_gnt_o = refill_req_i && (state == IDLE) && !flush_req_i;

    // Hit first, then grant, so the grant owns any shared nodes.
    assign plru_hit  = hit_valid_i  ? plru_touch(plru_q, hit_idx_i)      : plru_q;
    assign plru_next = refill_gnt_o ? plru_touch(plru_hit, refill_idx_o) : plru_hit;

    always_comb begin
        vpn_eq = 1'b0;
        if (tag_is_1G_i)
            vpn_eq = (tag_vpn_i[26:18] == f_vpn[26:18]);
        else if (tag_is_2M_i)
            vpn_eq = (tag_vpn_i[26:9] == f_vpn[26:9]);
        else
            vpn_eq = (tag_vpn_i == f_vpn);
    end

    assign match = tag_valid_i && (f_all_asid || (tag_asid_i == f_asid)) && (f_all_addr || vpn_eq);

    assign tag_idx_o   = cnt;
    assign inv_idx_o   = cnt;
    assign inv_valid_o = (state == SCAN) && match;
    assign inv_all_o   = (state == IDLE) && flush_req_i && flush_all_asid_i && flush_all_addr_i;
    assign flush_ack_o = (state == DONE);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            f_asid     <= '0;
            f_vpn      <= '0;
            f_all_asid <= 1'b0;
            f_all_addr <= 1'b0;
            plru_q     <= '0;
        end else begin
            plru_q <= plru_next;
            case (state)
                IDLE: begin
                    if (flush_req_i) begin
                        f_asid     <= flush_asid_i;
                        f_vpn      <= flush_vpn_i;
                        f_all_asid <= flush_all_asid_i;
                        f_all_addr <= flush_all_addr_i;
                        cnt        <= '0;
                        state      <= (flush_all_asid_i && flush_all_addr_i) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (cnt == IDX_W'(TLB_ENTRIES - 1))
                        state <= DONE;
                    else
                        cnt <= cnt + 1'b1;
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tlb_maint_ctrl.md
Name: tlb_maint_ctrl

Overview:
Maintenance controller for one fully-associative 16-entry TLB tag array. Entry fields are asid, vpn2, vpn1, vpn0, is_2M, is_1G and valid. The block sequences sfence.vma-style flushes by scanning the tag array and invalidating matching entries, and it selects refill victims with a tree pseudo-LRU. It sits beside the TLB storage in the MMU and arbitrates array maintenance between the flush path and the refill (PTW) path.

Parameters:
TLB_ENTRIES, 16, number of TLB entries; must be a power of two and at least 2.
ASID_WIDTH, 16, ASID width in bits.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_req_i  in  1  flush request; held high until flush_ack_o
flush_all_asid_i  in  1  ignore ASID in the match (rs2==x0)
flush_all_addr_i  in  1  ignore VPN in the match (rs1==x0)
flush_asid_i  in  ASID_WIDTH  ASID to flush
flush_vpn_i  in  27  VPN to flush, ordered {vpn2,vpn1,vpn0}
flush_ack_o  out  1  one-cycle pulse when the flush completes
busy_o  out  1  high while state is not IDLE
tag_idx_o  out  $clog2(TLB_ENTRIES)  entry index being read
tag_valid_i, tag_is_2M_i, tag_is_1G_i  in  1 each  fields of the entry at tag_idx_o (combinational read)
tag_asid_i  in  ASID_WIDTH  asid of the entry at tag_idx_o
tag_vpn_i  in  27  {vpn2,vpn1,vpn0} of the entry at tag_idx_o
valid_vec_i  in  TLB_ENTRIES  valid bit of every entry
inv_valid_o  out  1  invalidate the entry at inv_idx_o this cycle
inv_idx_o  out  $clog2(TLB_ENTRIES)  entry index to invalidate
inv_all_o  out  1  invalidate all entries this cycle
refill_req_i  in  1  PTW requests a victim slot
refill_gnt_o  out  1  victim granted this cycle
refill_idx_o  out  $clog2(TLB_ENTRIES)  victim index
hit_valid_i  in  1  lookup hit, used for the LRU update
hit_idx_i  in  $clog2(TLB_ENTRIES)  index of the entry that hit

Behaviour:
- Reset (async assert): all outputs 0, state IDLE, scan counter 0, PLRU tree bits all 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE, flush_req_i=1:
  - Latch flush_asid_i, flush_vpn_i, flush_all_asid_i and flush_all_addr_i.
  - If both all flags are set: assert inv_all_o this cycle and go to DONE.
  - Otherwise go to SCAN with counter=0.
- SCAN:
  - tag_idx_o = counter.
  - inv_valid_o = match (combinational); inv_idx_o = counter.
  - match = tag_valid_i && (all_asid || tag_asid_i==asid) && (all_addr || vpn_eq).
  - vpn_eq when is_1G: vpn2 compared only.
  - vpn_eq when is_2M: vpn2 and vpn1 compared.
  - vpn_eq otherwise: all 27 bits compared.
  - The counter increments every cycle. At counter==TLB_ENTRIES-1 go to DONE; the counter does not wrap further.
- DONE: flush_ack_o=1 for one cycle, then IDLE.
- Flush latency:
  - Request accepted at cycle k.
  - Scan covers cycles k+1 to k+16.
  - Ack at cycle k+17.
  - For a flush-all, ack at cycle k+1.
- Refill arbitration:
  - refill_gnt_o = refill_req_i && state==IDLE && !flush_req_i; flush has priority.
  - Refills are never granted while busy_o=1.
  - refill_idx_o = lowest index with valid_vec_i bit 0. If all entries are valid, refill_idx_o = the PLRU victim.
  - refill_idx_o is valid in any cycle in which refill_gnt_o=1.
- PLRU: binary tree of TLB_ENTRIES-1 bits.
  - Node bit 0 means the victim lies in the lower half; 1 means the upper half.
  - An access to an entry sets every node on its path to point away from it.
  - Accesses are a hit (hit_valid_i) and a refill grant (index refill_idx_o).
  - If both occur in the same cycle, apply the hit first, then the grant; the grant wins on shared nodes.
  - Hit updates are accepted in every state.
  - Flushes do not modify the PLRU state.
- Reset asserted mid-scan: return to IDLE immediately. No ack is issued, and inv_valid_o drops asynchronously.
- A flush_req_i that stays high after ack is treated as a new request in the following IDLE cycle; requesters must drop it on ack.

Test Plan:
- After reset, valid_vec_i all 1, four back-to-back refill grants -> refill_idx_o = 0, 8, 4, 12. With valid_vec_i=16'hFFF7 -> refill_idx_o = 3.
- Flush with all_asid=1 and all_addr=1 at cycle k -> inv_all_o=1 at cycle k only, flush_ack_o=1 at cycle k+1, no inv_valid_o.
- Entries 3 and 7 have asid 5, all others asid 2; flush asid=5 with all_addr=1 -> inv_valid_o only at idx 3 and 7, ack at k+17, busy_o=1 from k+1 to k+17.
- Entry 5: is_1G, vpn2 equal to the flush VPN, vpn1 and vpn0 different -> invalidated. Entry 6: 4K page, only vpn0 differs -> not invalidated.
- flush_req_i and refill_req_i rise in the same cycle -> flush accepted, refill_gnt_o=0 until the cycle after ack, then grant.
- rst_ni asserted during SCAN at index 6 -> outputs 0 immediately, no flush_ack_o; after release, state is IDLE, PLRU tree bits are 0 and refill_idx_o = 0 with all entries valid.
